// File: rtl/alu_pkg.sv
// Shared op-code encoding, widths and status-flag bundle for the pipelined ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_NOR  = 4'd3,
    ALU_ADD  = 4'd4,
    ALU_SUB  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_op_e;

  // Codes 11..15 are unassigned and report through the illegal flag.
  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: bitwise, add/sub, compares and shifts with status flags.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [WIDTH-1:0]    y_o,
  output alu_flags_t          flags_o
);

  localparam int SHW = $clog2(WIDTH);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;

  // SUB reuses the adder as a + ~b + 1, so carry=1 means "no borrow".
  assign is_sub = (op_i == ALU_SUB);
  assign b_eff  = is_sub ? ~b_i : b_i;
  assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  // Upper bits of b are deliberately ignored for shifts.
  assign shamt  = b_i[SHW-1:0];

  // Result mux plus flags; zero/negative always follow the final result.
  always_comb begin
    y_o     = '0;
    flags_o = '0;
    case (op_i)
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_NOR:  y_o = ~(a_i | b_i);
      ALU_ADD, ALU_SUB: begin
        y_o              = sum[WIDTH-1:0];
        flags_o.carry    = sum[WIDTH];
        flags_o.overflow = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SLT:  y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: y_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $signed(a_i) >>> shamt;
      default:  flags_o.illegal = 1'b1;
    endcase
    flags_o.zero     = (y_o == '0);
    flags_o.negative = y_o[WIDTH-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: operand register stage, then compute-and-register result stage.
// Latency: beat accepted at edge N is presented with out_valid after edge N+1; 1 beat/cycle.
// Backpressure: valid/ready; out_ready ripples combinationally to in_ready, stalled output held stable.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    y,
  output logic                zero,
  output logic                negative,
  output logic                carry,
  output logic                overflow,
  output logic                illegal
);

  // Stage 1: registered operands
  logic                s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]    s1_a_q, s1_b_q;
  logic [ALU_OP_W-1:0] s1_op_q;

  // Stage 2: registered result
  logic                s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]    y_q, y_d;
  alu_flags_t          flags_q, flags_d;

  logic                s1_load, s2_load, in_fire;
  logic [WIDTH-1:0]    core_y;
  alu_flags_t          core_flags;

  // A stage may load when it is empty or its contents leave this edge.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign in_fire  = in_valid && s1_load;

  assign s1_valid_d = s1_load ? in_valid : s1_valid_q;
  assign s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
  assign y_d        = (s2_load && s1_valid_q) ? core_y : y_q;
  assign flags_d    = (s2_load && s1_valid_q) ? core_flags : flags_q;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .op_i    (s1_op_q),
    .y_o     (core_y),
    .flags_o (core_flags)
  );

  // Valid bits and result/flags reset so a reset drops every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      flags_q    <= flags_d;
    end
  end

  // Operand capture needs no reset: it is qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_a_q  <= a;
      s1_b_q  <= b;
      s1_op_q <= op;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: table vectors through a scoreboard, plus stall/reset/8-bit sequences.
// Latency: checks the two-edge accept-to-output timing and full throughput.
// Backpressure: exercises output stalls, in_ready drop and ordered drain.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, y;
  logic [3:0]  op;
  logic        zero, negative, carry, overflow, illegal;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, y8;
  logic [3:0]  op8;
  logic        zero8, negative8, carry8, overflow8, illegal8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] y;
    alu_flags_t  f;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    alu_flags_t  f;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t cur_exp;
  exp_t mon_e;
  int   acc_cnt = 0;
  int   out_cnt = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .illegal(illegal)
  );

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .y(y8), .zero(zero8), .negative(negative8), .carry(carry8),
    .overflow(overflow8), .illegal(illegal8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] top,
                         input logic [31:0] ty, input logic [4:0] tf);
    vec_t v;
    v.a = ta; v.b = tb; v.op = top; v.y = ty; v.f = tf;
    vecs.push_back(v);
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(cur_exp);
      acc_cnt++;
    end
    if (rst_n && out_valid && out_ready) begin
      out_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got y=%h expected no beat", y);
      end else begin
        mon_e = sb.pop_front();
        chk("out_y", {32'h0, y}, {32'h0, mon_e.y});
        chk("out_flags", {59'h0, zero, negative, carry, overflow, illegal}, {59'h0, mon_e.f});
      end
    end
  end

  // Present one beat and hold it until it is accepted (bounded).
  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] top,
                      input logic [31:0] ey, input logic [4:0] ef);
    int n;
    n = 0;
    a = ta; b = tb; op = top;
    cur_exp.y = ey; cur_exp.f = ef;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input string name, input logic [7:0] ta, input logic [7:0] tb,
                      input logic [3:0] top, input logic [7:0] ey, input logic [4:0] ef);
    int n;
    n = 0;
    a8 = ta; b8 = tb; op8 = top;
    in_valid8 = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready8 && n < 20);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid8) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid=0 required 1", name);
    end else begin
      chk({name, "_y"}, {56'h0, y8}, {56'h0, ey});
      chk({name, "_flags"}, {59'h0, zero8, negative8, carry8, overflow8, illegal8}, {59'h0, ef});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ycap;
    int          base, ob;
    time         t0, t1;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; out_ready8 = 1'b1;
    cur_exp.y = '0; cur_exp.f = '0;

    // flags order: {zero, negative, carry, overflow, illegal}
    add_vec(32'h00000000, 32'hFFFFFFFF, ALU_AND,  32'h00000000, 5'b10000);
    add_vec(32'hFFFFFFFF, 32'hFFFFFFFF, ALU_AND,  32'hFFFFFFFF, 5'b01000);
    add_vec(32'h7FFFFFFF, 32'h00000001, ALU_ADD,  32'h80000000, 5'b01010);
    add_vec(32'hFFFFFFFF, 32'h00000001, ALU_ADD,  32'h00000000, 5'b10100);
    add_vec(32'h00000003, 32'h00000005, ALU_SUB,  32'hFFFFFFFE, 5'b01000);
    add_vec(32'h00000005, 32'h00000003, ALU_SUB,  32'h00000002, 5'b00100);
    add_vec(32'h80000000, 32'h00000001, ALU_SUB,  32'h7FFFFFFF, 5'b00110);
    add_vec(32'hFFFFFFFF, 32'h00000001, ALU_SLT,  32'h00000001, 5'b00000);
    add_vec(32'hFFFFFFFF, 32'h00000001, ALU_SLTU, 32'h00000000, 5'b10000);
    add_vec(32'h00000001, 32'hFFFFFFFF, ALU_SLT,  32'h00000000, 5'b10000);
    add_vec(32'h00000001, 32'hFFFFFFFF, ALU_SLTU, 32'h00000001, 5'b00000);
    add_vec(32'h80000000, 32'h00000024, ALU_SRA,  32'hF8000000, 5'b01000);
    add_vec(32'h00000001, 32'h0000001F, ALU_SLL,  32'h80000000, 5'b01000);
    add_vec(32'h80000000, 32'h0000001F, ALU_SRL,  32'h00000001, 5'b00000);
    add_vec(32'h12345678, 32'h00000020, ALU_SRL,  32'h12345678, 5'b00000);
    add_vec(32'h0F0F0000, 32'h0000F0F0, ALU_OR,   32'h0F0FF0F0, 5'b00000);
    add_vec(32'hFFFF0000, 32'hFF00FF00, ALU_XOR,  32'h00FFFF00, 5'b00000);
    add_vec(32'h00000000, 32'h00000000, ALU_NOR,  32'hFFFFFFFF, 5'b01000);
    add_vec(32'h00001234, 32'h00005678, 4'd13,    32'h00000000, 5'b10001);
    add_vec(32'hDEADBEEF, 32'h00000001, 4'd15,    32'h00000000, 5'b10001);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_y", {32'h0, y}, 64'd0);
    chk("rst_flags", {59'h0, zero, negative, carry, overflow, illegal}, 64'd0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
    chk("rst_out_valid8", {63'h0, out_valid8}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accept at edge N, result valid only after edge N+1
    a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; op = ALU_AND;
    cur_exp.y = 32'h0; cur_exp.f = 5'b10000;
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", {63'h0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_after_accept", {63'h0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("lat_next_edge", {63'h0, out_valid}, 64'd1);
    wait_drain();

    // Table stream back-to-back with out_ready high: one beat per cycle
    t0 = $time;
    for (int i = 0; i < vecs.size(); i++)
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].y, vecs[i].f);
    t1 = $time;
    chk("throughput_cycles", 64'((t1 - t0) / 10), 64'(vecs.size()));
    wait_drain();

    // Backpressure: out_ready low for 4 cycles while 5 beats are offered
    out_ready = 1'b0;
    base = acc_cnt;
    ob = out_cnt;
    ycap = '0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(32'h10 + 32'(i), 32'h100, ALU_ADD, 32'h110 + 32'(i), 5'b00000);
      end
      begin
        repeat (3) @(negedge clk);
        ycap = y;
        @(negedge clk);
        chk("bp_accepted", 64'(acc_cnt - base), 64'd2);
        chk("bp_in_ready", {63'h0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'h0, out_valid}, 64'd1);
        chk("bp_y_stable", {32'h0, y}, {32'h0, ycap});
        chk("bp_y_head", {32'h0, y}, 64'h110);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_out_count", 64'(out_cnt - ob), 64'd5);

    // Reset with two beats in flight: immediate drop, nothing afterwards
    out_ready = 1'b0;
    send(32'h1, 32'h2, ALU_ADD, 32'h3, 5'b00000);
    send(32'h4, 32'h5, ALU_ADD, 32'h9, 5'b00000);
    chk("pre_rst_out_valid", {63'h0, out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("midrst_y", {32'h0, y}, 64'd0);
    chk("midrst_flags", {59'h0, zero, negative, carry, overflow, illegal}, 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {63'h0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;

    // 8-bit instance
    run8("w8_add", 8'h80, 8'h80, ALU_ADD, 8'h00, 5'b10110);
    run8("w8_sll", 8'h01, 8'h0B, ALU_SLL, 8'h08, 5'b00000);
    run8("w8_sra", 8'h90, 8'h02, ALU_SRA, 8'hE4, 5'b01000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
